// File: rtl/rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : rx_frame_checker
// Purpose  : Receive-side frame checker. Assembles strobed line bits into a
//            start / data (LSB first) / optional parity / stop frame, checks
//            parity and stop bit, and publishes good words.
// Ports    : CLK, RST          - clock, synchronous active-high reset
//            sampled_bit       - resolved line value, valid when bit_valid=1
//            bit_valid         - one-cycle strobe qualifying sampled_bit
//            PAR_EN, PAR_TYPE  - parity enable / type (0 even, 1 odd),
//                                captured at start-bit acceptance
//            P_DATA            - last correctly received word
//            data_valid        - pulse when P_DATA is updated
//            par_err, stp_err  - parity / stop-bit error pulses
//            busy              - frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module rx_frame_checker #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   sampled_bit,
    input  logic                   bit_valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYPE,
    output logic [DATA_LENGTH-1:0] P_DATA,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   busy
);

    localparam int                 c_cnt_w    = $clog2(DATA_LENGTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_LENGTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [DATA_LENGTH-1:0] r_shift;
    logic [DATA_LENGTH-1:0] r_p_data;
    logic                   r_xor;
    logic                   r_par_mis;
    logic                   r_par_en;
    logic                   r_par_type;
    logic                   r_data_valid;
    logic                   r_par_err;
    logic                   r_stp_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: every transition is qualified by bit_valid
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (bit_valid) begin
            case (r_state)
                c_st_idle:   if (!sampled_bit) w_next_state = c_st_data;
                c_st_data: begin
                    if (r_cnt == c_last_bit) begin
                        w_next_state = r_par_en ? c_st_parity : c_st_stop;
                    end
                end
                c_st_parity: w_next_state = c_st_stop;
                c_st_stop:   w_next_state = c_st_idle;
                default:     w_next_state = c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath and result pulses
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_xor        <= 1'b0;
            r_par_mis    <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_type   <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            if (bit_valid) begin
                case (r_state)
                    c_st_idle: begin
                        // Start bit: freeze the frame format and clear the
                        // per-frame accumulators. The shift register needs no
                        // clear since every data bit overwrites it.
                        if (!sampled_bit) begin
                            r_cnt      <= '0;
                            r_xor      <= 1'b0;
                            r_par_mis  <= 1'b0;
                            r_par_en   <= PAR_EN;
                            r_par_type <= PAR_TYPE;
                        end
                    end
                    c_st_data: begin
                        // LSB first: after DATA_LENGTH shifts the first bit
                        // received sits in bit 0.
                        r_shift <= {sampled_bit, r_shift[DATA_LENGTH-1:1]};
                        r_cnt   <= r_cnt + c_cnt_one;
                        r_xor   <= r_xor ^ sampled_bit;
                    end
                    c_st_parity: begin
                        // Odd parity expects the inverse of the data XOR.
                        r_par_mis <= sampled_bit ^ (r_xor ^ r_par_type);
                    end
                    c_st_stop: begin
                        r_stp_err <= ~sampled_bit;
                        r_par_err <= r_par_mis;
                        if (sampled_bit && !r_par_mis) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_frame_checker
// Purpose  : Self-checking bench for rx_frame_checker. Expected frame results
//            are queued when each stop bit is driven and compared when the
//            checker emits its result pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_frame_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       sampled_bit;
    logic       bit_valid;
    logic       PAR_EN;
    logic       PAR_TYPE;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pd;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_pdata = 8'h00;
    int         n_vec = 0;
    int         n_err = 0;

    rx_frame_checker #(.DATA_LENGTH(8)) u_dut (
        .CLK         (CLK),
        .RST         (RST),
        .sampled_bit (sampled_bit),
        .bit_valid   (bit_valid),
        .PAR_EN      (PAR_EN),
        .PAR_TYPE    (PAR_TYPE),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: any result pulse pops one expected frame result.
    always @(negedge CLK) begin
        exp_t e;
        if (data_valid || par_err || stp_err) begin
            if (sb_q.size() == 0) begin
                check_val("spurious_pulse", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
                check_val("par_err",    {31'd0, par_err},    {31'd0, e.pe});
                check_val("stp_err",    {31'd0, stp_err},    {31'd0, e.se});
                check_val("p_data",     {24'd0, P_DATA},     {24'd0, e.pd});
            end
        end
    end

    // One strobed bit, then 'gap' idle cycles with noise on the line.
    task automatic strobe(input logic b, input int gap);
        sampled_bit = b;
        bit_valid   = 1'b1;
        @(posedge CLK);
        #1;
        bit_valid   = 1'b0;
        sampled_bit = 1'($urandom);
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pen, input logic ptype,
                              input logic pbit, input logic stop, input logic toggle);
        exp_t e;
        logic exp_par;
        logic mis;
        PAR_EN   = pen;
        PAR_TYPE = ptype;
        strobe(1'b0, int'($urandom_range(0, 2)));
        check_val("busy_after_start", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            strobe(data[i], int'($urandom_range(0, 2)));
            if (toggle && i == 3) begin
                PAR_TYPE = ~PAR_TYPE;
                PAR_EN   = ~PAR_EN;
            end
        end
        if (pen) strobe(pbit, int'($urandom_range(0, 2)));
        exp_par = (^data) ^ ptype;
        mis     = pen && (pbit != exp_par);
        e.dv    = stop && !mis;
        e.pe    = mis;
        e.se    = !stop;
        if (e.dv) exp_pdata = data;
        e.pd    = exp_pdata;
        sb_q.push_back(e);
        strobe(stop, 0);
        check_val("busy_after_stop", {31'd0, busy}, 32'd0);
    endtask

    task automatic settle(input string tag);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        check_val(tag, sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       pen, pt, good, stop;
        RST = 1'b1; sampled_bit = 1'b1; bit_valid = 1'b0; PAR_EN = 1'b0; PAR_TYPE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy",       {31'd0, busy},       32'd0);
        check_val("rst_p_data",     {24'd0, P_DATA},     32'd0);
        check_val("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check_val("rst_par_err",    {31'd0, par_err},    32'd0);
        check_val("rst_stp_err",    {31'd0, stp_err},    32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Even parity, good frame.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        settle("sb_empty_even");
        // Odd parity with parity bit 0 -> parity error, P_DATA held.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        settle("sb_empty_odd");
        // Bad stop then a good frame back-to-back.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle("sb_empty_b2b");
        check_val("p_data_3c", {24'd0, P_DATA}, 32'h3C);

        // Reset after 4 data bits: no pulse, P_DATA cleared.
        PAR_EN = 1'b0;
        strobe(1'b0, 0);
        strobe(1'b1, 1); strobe(1'b0, 0); strobe(1'b0, 2); strobe(1'b0, 0);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        exp_pdata = 8'h00;
        check_val("busy_after_rst",   {31'd0, busy},   32'd0);
        check_val("p_data_after_rst", {24'd0, P_DATA}, 32'd0);
        settle("sb_empty_rst");
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        settle("sb_empty_81");
        check_val("p_data_81", {24'd0, P_DATA}, 32'h81);

        // Idle strobes with line high are ignored.
        for (int i = 0; i < 3; i++) begin
            strobe(1'b1, 1);
            check_val("idle_ignore_busy", {31'd0, busy}, 32'd0);
        end
        // Odd parity captured at start; PAR_TYPE/PAR_EN flip mid-frame.
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        settle("sb_empty_toggle");
        // Parity and stop errors together.
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        settle("sb_empty_both");

        // Random frames.
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom);
            pen  = 1'($urandom);
            pt   = 1'($urandom);
            good = ($urandom_range(0, 3) != 0);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, pen, pt, (^d) ^ pt ^ ~good, stop, 1'($urandom));
        end
        settle("sb_empty_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_frame_checker.md
RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 8, meaning the number of data bits per frame.
REQ-002 SHALL have port CLK  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sampled_bit  input  1  line value resolved by the upstream oversampling sampler.
REQ-005 SHALL have port bit_valid  input  1  one-cycle strobe; sampled_bit is valid in that cycle only.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port PAR_TYPE  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_LENGTH  last correctly received data word.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse when the stop bit is 0.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, DATA, PARITY, STOP; all state changes occur only in cycles where bit_valid=1.
REQ-014 IDLE: bit_valid with sampled_bit=0 SHALL be accepted as the start bit -> DATA; bit_valid with sampled_bit=1 SHALL be ignored.
REQ-015 On start-bit acceptance SHALL capture PAR_EN and PAR_TYPE; later changes SHALL NOT affect the current frame.
REQ-016 DATA: each strobe SHALL shift sampled_bit into the data register LSB-first, increment a bit counter (width clog2(DATA_LENGTH)+1), and update a running XOR.
REQ-017 After the DATA_LENGTH-th data strobe SHALL go to PARITY if captured PAR_EN=1, else to STOP.
REQ-018 PARITY: expected bit SHALL be running XOR for even parity and its inverse for odd; the mismatch result SHALL be held internally until the stop strobe, then -> STOP.
REQ-019 STOP: on strobe SHALL return to IDLE and, in the following cycle, pulse stp_err if sampled_bit=0 and pulse par_err if a mismatch was recorded.
REQ-020 data_valid SHALL pulse, and P_DATA SHALL load the shifted word, in that same following cycle only if stop bit=1 and no parity mismatch; otherwise P_DATA SHALL hold its value.
REQ-021 par_err and stp_err MAY pulse together in the same cycle; data_valid SHALL never pulse together with either error.
REQ-022 busy SHALL be 1 from the cycle after start-bit acceptance through the cycle the FSM re-enters IDLE, inclusive of neither the pulse cycle.
REQ-023 A start bit SHALL be accepted on the strobe immediately following a stop strobe (back-to-back frames, no idle gap).
REQ-024 Cycles without bit_valid SHALL leave state, counter, data register and running XOR unchanged.

Reset
REQ-025 RST=1 at any clock edge, including mid-frame, SHALL force IDLE, clear the counter, running XOR, mismatch flag, and P_DATA to 0, and drive data_valid, par_err, stp_err and busy to 0.
REQ-026 A frame interrupted by reset SHALL produce no output pulse; the next accepted start bit SHALL begin a fresh frame.

Verification
REQ-027 Bench SHALL cover: PAR_EN=1, PAR_TYPE=0, data 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), parity 0, stop 1 -> data_valid pulse, P_DATA=0xA5, no errors.
REQ-028 Bench SHALL cover: PAR_EN=1, PAR_TYPE=1, data 0xA5, parity 0, stop 1 -> par_err pulse, no data_valid, P_DATA keeps prior value.
REQ-029 Bench SHALL cover: PAR_EN=0, data 0x3C, stop 0 -> stp_err pulse only, P_DATA unchanged; then a good 0x3C frame back-to-back -> data_valid, P_DATA=0x3C.
REQ-030 Bench SHALL cover: RST asserted after 4 data bits -> busy=0 next cycle, P_DATA=0x00, no pulses; next frame 0x81 (PAR_EN=0) -> P_DATA=0x81.
REQ-031 Bench SHALL cover: IDLE strobes with sampled_bit=1 and PAR_TYPE toggled mid-frame -> no state change in IDLE; parity checked against the PAR_TYPE captured at start.
